// File: rtl/clk_div_gen.sv
// clk_div_gen: NUM_CH independent programmable clock-enable style waveforms
// derived from one reference clock. Each channel has an active period (div)
// and high time (high), plus a shadow copy that is loaded through a
// valid/ready config port and applied only at a period boundary, so
// reprogramming and enable/disable never produce runt pulses.
//
// Optional feature: define CLK_DIV_GEN_TICK_EN to add the `tick` output,
// a one-cycle pulse in the cycle where clk_out[i] goes 0->1.
//
// Handshake: a config transfer happens on a rising clk edge where
// cfg_valid && cfg_ready. cfg_ready is combinational on cfg_ch and is low
// while the addressed channel still holds an unapplied shadow config.
// A transfer with illegal values is consumed but reported by a one-cycle
// cfg_err pulse and leaves shadow/pending untouched.
//
// Per-channel FSM state is visible hierarchically as g_ch[i].state_q.
module clk_div_gen #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int REF_FREQ_MHZ = 100,
  parameter int DEF_DIV      = 10,
  parameter int DEF_HIGH     = 5,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pending,
`ifdef CLK_DIV_GEN_TICK_EN
  output logic [NUM_CH-1:0] tick,
`endif
  output logic [NUM_CH-1:0] clk_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } ch_state_e;

  // Elaboration-time sanity checks on the parameter set.
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("clk_div_gen: NUM_CH must be 1..16");
  end
  if (DEF_DIV < 2) begin : g_bad_def_div
    $error("clk_div_gen: DEF_DIV must be >= 2");
  end
  if (DEF_HIGH < 1 || DEF_HIGH > DEF_DIV - 1) begin : g_bad_def_high
    $error("clk_div_gen: DEF_HIGH must be 1..DEF_DIV-1");
  end
  if (REF_FREQ_MHZ < 1) begin : g_bad_ref
    $error("clk_div_gen: REF_FREQ_MHZ must be positive");
  end
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("clk_div_gen: CNT_W must be >= 2");
  end

  localparam logic [CNT_W-1:0] DEF_DIV_V  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH_V = CNT_W'(DEF_HIGH);

  logic cfg_ch_ok;
  logic cfg_legal;
  logic cfg_xfer;

  // Channel index range check and value legality of the request.
  always_comb begin
    cfg_ch_ok = (int'(cfg_ch) < NUM_CH);
    cfg_legal = cfg_ch_ok
                && (cfg_div >= CNT_W'(2))
                && (cfg_high != '0)
                && (cfg_high < cfg_div);
  end

  // Ready is low only while the addressed channel has an unapplied shadow.
  always_comb begin
    cfg_ready = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cfg_ch == CH_W'(k)) begin
        cfg_ready = !pending[k];
      end
    end
  end

  assign cfg_xfer = cfg_valid && cfg_ready;

  // Rejected transfers produce a single-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_xfer && !cfg_legal;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, high_q;
    logic [CNT_W-1:0] sdiv_q, shigh_q;
    logic [CNT_W-1:0] high_eff;
    logic             pend_q;
    logic             clk_q, clk_d;
    logic             at_end;
    logic             apply;
    logic             accept;

    // Last cycle of the current period, and whether the shadow lands now.
    always_comb begin
      at_end   = (cnt_q == div_q - 1'b1);
      apply    = pend_q && ((state_q == S_IDLE) || at_end);
      accept   = cfg_xfer && cfg_legal && (cfg_ch == CH_W'(i));
      high_eff = apply ? shigh_q : high_q;
    end

    // Next-state, counter and waveform decode; a new period sees new values.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clk_d   = 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (ch_en[i]) begin
            state_d = S_RUN;
          end
        end
        S_RUN, S_STOP: begin
          cnt_d = at_end ? '0 : cnt_q + 1'b1;
          if (ch_en[i]) begin
            state_d = S_RUN;
          end else if (at_end) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_STOP;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
      clk_d = (state_d != S_IDLE) && (cnt_d < high_eff);
    end

    // Channel state, counter, active/shadow config and output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        div_q   <= DEF_DIV_V;
        high_q  <= DEF_HIGH_V;
        sdiv_q  <= DEF_DIV_V;
        shigh_q <= DEF_HIGH_V;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        clk_q   <= clk_d;
        if (apply) begin
          div_q  <= sdiv_q;
          high_q <= shigh_q;
        end
        if (accept) begin
          sdiv_q  <= cfg_div;
          shigh_q <= cfg_high;
        end
        if (accept) begin
          pend_q <= 1'b1;
        end else if (apply) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign pending[i] = pend_q;
    assign clk_out[i] = clk_q;

`ifdef CLK_DIV_GEN_TICK_EN
    logic tick_q;

    // Pulse in the cycle where the registered waveform rises.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tick_q <= 1'b0;
      end else begin
        tick_q <= clk_d && !clk_q;
      end
    end

    assign tick[i] = tick_q;
`else
    // No rising-edge tick output in this build.
`endif
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen (NUM_CH=2, CNT_W=16, defaults 10/5).
// Inputs are driven on the falling edge; outputs are sampled 1ns after the
// rising edge. A segment table holds runs of identical cycles with their
// hand-computed expected outputs; reset and tick corners are hand-written.
module tb_clk_div_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 1;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_high;
  logic              cfg_err;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] clk_out;
`ifdef CLK_DIV_GEN_TICK_EN
  logic [NUM_CH-1:0] tick;
`endif

  int errors = 0;
  int checks = 0;

  clk_div_gen #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .REF_FREQ_MHZ(100),
    .DEF_DIV(10),
    .DEF_HIGH(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch_en(ch_en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_high(cfg_high),
    .cfg_err(cfg_err),
    .pending(pending),
`ifdef CLK_DIV_GEN_TICK_EN
    .tick(tick),
`endif
    .clk_out(clk_out)
  );

  // Clock and safety timeout.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    int               n;
    logic [1:0]       en;
    logic             cv;
    logic [CH_W-1:0]  cch;
    logic [CNT_W-1:0] cdiv;
    logic [CNT_W-1:0] chigh;
    logic [1:0]       eclk;
    logic [1:0]       epend;
    logic             eerr;
    logic             erdy;
  } seg_t;

  seg_t tbl[$];

  function automatic seg_t seg(int n, logic [1:0] en, logic cv, logic cch,
                               int cdiv, int chigh, logic [1:0] eclk,
                               logic [1:0] epend, logic eerr, logic erdy);
    seg_t s;
    s.n     = n;
    s.en    = en;
    s.cv    = cv;
    s.cch   = cch;
    s.cdiv  = CNT_W'(cdiv);
    s.chigh = CNT_W'(chigh);
    s.eclk  = eclk;
    s.epend = epend;
    s.eerr  = eerr;
    s.erdy  = erdy;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] en, input logic cv, input logic cch,
                       input logic [CNT_W-1:0] cdiv, input logic [CNT_W-1:0] chigh);
    ch_en     = en;
    cfg_valid = cv;
    cfg_ch    = cch;
    cfg_div   = cdiv;
    cfg_high  = chigh;
  endtask

  logic [1:0] prev_clk;
  logic [1:0] exp_clk;

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0, '0, '0);
    prev_clk = 2'b00;

    // Segment table: n, ch_en, cfg_valid, cfg_ch, cfg_div, cfg_high,
    // expected clk_out, pending, cfg_err, cfg_ready.
    // Defaults 10/5 on ch0, ch1 idle.
    tbl.push_back(seg(5, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(5, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(seg(5, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(5, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    // Mid-period config 4/1: current period completes, then 1 high / 3 low.
    tbl.push_back(seg(2, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(1, 2'b01, 1, 0, 4, 1, 2'b01, 2'b01, 0, 0));
    tbl.push_back(seg(2, 2'b01, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0));
    tbl.push_back(seg(5, 2'b01, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0));
    tbl.push_back(seg(1, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(3, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(seg(1, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(3, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    // Illegal configs 1/0 and 8/8: error pulse, nothing else changes.
    tbl.push_back(seg(1, 2'b01, 1, 0, 1, 0, 2'b01, 2'b00, 1, 1));
    tbl.push_back(seg(1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(seg(1, 2'b01, 1, 0, 8, 8, 2'b00, 2'b00, 1, 1));
    tbl.push_back(seg(1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(seg(1, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(3, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    // Back to 10/5, applied at the next wrap.
    tbl.push_back(seg(1, 2'b01, 1, 0, 10, 5, 2'b01, 2'b01, 0, 0));
    tbl.push_back(seg(3, 2'b01, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0));
    tbl.push_back(seg(2, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    // Drop enable in high phase: 3 high + 5 low finish, then held low.
    tbl.push_back(seg(3, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(5, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(seg(4, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    // Re-enable restarts with a full high phase.
    tbl.push_back(seg(5, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(5, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    // Brief drop and re-assert before period end: no interruption.
    tbl.push_back(seg(2, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(2, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(1, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(5, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(seg(1, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1));
    // Config idle ch1 to 7/3: applied the next cycle, then enable ch1.
    tbl.push_back(seg(1, 2'b01, 1, 1, 7, 3, 2'b01, 2'b10, 0, 0));
    tbl.push_back(seg(1, 2'b01, 0, 1, 0, 0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(seg(1, 2'b11, 0, 0, 0, 0, 2'b11, 2'b00, 0, 1));
    tbl.push_back(seg(1, 2'b11, 0, 0, 0, 0, 2'b11, 2'b00, 0, 1));
    tbl.push_back(seg(1, 2'b11, 0, 0, 0, 0, 2'b10, 2'b00, 0, 1));
    tbl.push_back(seg(4, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(seg(1, 2'b11, 0, 0, 0, 0, 2'b11, 2'b00, 0, 1));
    // ch0 reconfig 3/2 left pending when reset arrives.
    tbl.push_back(seg(1, 2'b11, 1, 0, 3, 2, 2'b11, 2'b01, 0, 0));
    tbl.push_back(seg(1, 2'b11, 0, 0, 0, 0, 2'b11, 2'b01, 0, 0));

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_cfg_err", 32'(cfg_err), 32'h0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
`ifdef CLK_DIV_GEN_TICK_EN
    chk("rst_tick", 32'(tick), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[s]) begin
      for (int c = 0; c < tbl[s].n; c++) begin
        @(negedge clk);
        drive(tbl[s].en, tbl[s].cv, tbl[s].cch, tbl[s].cdiv, tbl[s].chigh);
        @(posedge clk);
        #1;
        chk($sformatf("seg%0d_c%0d_clk_out", s, c), 32'(clk_out), 32'(tbl[s].eclk));
        chk($sformatf("seg%0d_c%0d_pending", s, c), 32'(pending), 32'(tbl[s].epend));
        chk($sformatf("seg%0d_c%0d_cfg_err", s, c), 32'(cfg_err), 32'(tbl[s].eerr));
        chk($sformatf("seg%0d_c%0d_cfg_ready", s, c), 32'(cfg_ready), 32'(tbl[s].erdy));
`ifdef CLK_DIV_GEN_TICK_EN
        chk($sformatf("seg%0d_c%0d_tick", s, c), 32'(tick),
            32'(tbl[s].eclk & ~prev_clk));
`endif
        prev_clk = tbl[s].eclk;
      end
    end

    // Asynchronous reset mid-run with a pending config on ch0.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_clk_out", 32'(clk_out), 32'h0);
    chk("midrst_pending", 32'(pending), 32'h0);
    chk("midrst_cfg_err", 32'(cfg_err), 32'h0);
    chk("midrst_cfg_ready", 32'(cfg_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 1'b0, 1'b0, '0, '0);
    // Both channels back on defaults 10/5; the lost 3/2 must not appear.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      exp_clk = ((k % 10) < 5) ? 2'b11 : 2'b00;
      chk($sformatf("postrst_k%0d_clk_out", k), 32'(clk_out), 32'(exp_clk));
      chk($sformatf("postrst_k%0d_pending", k), 32'(pending), 32'h0);
    end

`ifdef CLK_DIV_GEN_TICK_EN
    // Tick alignment with ch0 programmed to 4/2 while idle.
    @(negedge clk);
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 1'b1, 1'b0, 16'd4, 16'd2);
    @(negedge clk);
    drive(2'b01, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("tick4_k%0d_clk_out", k), 32'(clk_out), ((k % 4) < 2) ? 32'h1 : 32'h0);
      chk($sformatf("tick4_k%0d_tick", k), 32'(tick), ((k % 4) == 0) ? 32'h1 : 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Synthesisable, parametrised successor to the fixed-frequency testbench clock source.
- Derives NUM_CH independent clock-enable-style output waveforms from one reference clock `clk` of REF_FREQ_MHZ.
- Each channel has a runtime-programmable period (divide ratio) and high time (duty).
- Reprogramming and enable/disable take effect glitch-free at period boundaries; used by peripherals and benches needing derived frequencies.

Parameters:
- NUM_CH, 2, number of independent output channels (1..16).
- CNT_W, 16, width of divide and high-time counters.
- REF_FREQ_MHZ, 100, reference clock frequency; informational, output freq = REF_FREQ_MHZ / div.
- DEF_DIV, 10, per-channel divide ratio loaded at reset (must be >= 2).
- DEF_HIGH, 5, per-channel high time in ref cycles loaded at reset (1..DEF_DIV-1).

Ports:
- clk  in  1  reference clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_en  in  NUM_CH  per-channel run enable, level sensitive.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; transfer when cfg_valid && cfg_ready.
- cfg_ch  in  CH_W  target channel, CH_W = max(1, clog2(NUM_CH)).
- cfg_div  in  CNT_W  new period in ref cycles.
- cfg_high  in  CNT_W  new high time in ref cycles.
- cfg_err  out  1  one-cycle pulse: rejected config.
- pending  out  NUM_CH  shadow config waiting to apply.
- clk_out  out  NUM_CH  generated waveforms, registered.

Behaviour:
- Reset (async assert, sync release): clk_out=0, cnt=0, active div/high = DEF_DIV/DEF_HIGH, pending=0, cfg_err=0, all channels IDLE; cfg_ready=1 after reset.
- Per-channel FSM: IDLE -> RUN when ch_en[i]=1 sampled; RUN -> STOPPING when ch_en[i]=0 sampled; STOPPING -> IDLE at period end (cnt==div-1); STOPPING -> RUN if ch_en re-asserted before period end (no interruption).
- RUN/STOPPING: cnt counts 0..div-1 then wraps to 0; clk_out[i] registered = (cnt_next < high). First clk_out rise is 1 cycle after ch_en sampled high; high phase = high cycles, low phase = div-high cycles, exact and repeating.
- IDLE: cnt held 0, clk_out=0. Disable never truncates a high phase; no runt pulses.
- Config accept: cfg_ready = !pending[cfg_ch] (combinational on cfg_ch). Legal iff cfg_div>=2 and 1<=cfg_high<=cfg_div-1, and cfg_ch<NUM_CH.
- Legal and accepted: value goes to the shadow register and pending[ch]=1 next cycle. Illegal: cfg_err=1 for one cycle, shadow/pending unchanged, handshake still completes.
- Apply: pending shadow copied to active on the cycle cnt wraps (cnt==div-1) in RUN/STOPPING, or on the next cycle if channel IDLE; pending clears same edge. A new period uses new values from its first cycle.
- Simultaneous: accept and apply on the same channel in the same cycle cannot occur (cfg_ready low while pending). Configs to different channels are independent.
- Reset mid-operation: all outputs return to reset values immediately; pending configs are lost.
- Arithmetic: counters unsigned CNT_W; no overflow since cnt <= div-1 <= 2^CNT_W-2.

Optional Feature:
- Macro CLK_DIV_GEN_TICK_EN.
- Defined: adds output tick [NUM_CH], a one-ref-cycle pulse coincident with each clk_out rising edge (cycle where clk_out goes 0->1), reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, ch_en=01, defaults DIV=10 HIGH=5 -> clk_out[0] rises 1 cycle after enable; 5 high / 5 low repeating (10 MHz at 100 MHz ref); clk_out[1]=0.
- Mid-period cfg ch0 div=4 high=1 -> pending[0]=1, cfg_ready low for ch0; current 10-cycle period completes, then 1 high / 3 low; pending clears at wrap.
- cfg div=1 high=0, then div=8 high=8 -> cfg_err pulses each time; waveform and pending unchanged.
- Drop ch_en[0] at cycle 2 of high phase -> remaining 3 high + 5 low complete, then clk_out=0 held; re-enable restarts with full high phase.
- Both channels: ch0 div=3 high=2, ch1 div=7 high=3, rst_n asserted mid-run -> outputs 0 immediately, defaults restored after release.
- With CLK_DIV_GEN_TICK_EN, div=4 high=2 -> tick pulses once every 4 cycles, aligned to clk_out rise.
